stream_prefetch_buf: RTL and testbench
======================================

// Module: stream_prefetch_buf
// PURPOSE
//  Multi-entry next-line prefetch buffer between the dcache read port and the AXI read bridge.
//  Each line miss fetches FETCH_LINES consecutive lines in one AXI read.
//  Line 0 goes to the cache; lines 1..FETCH_LINES-1 are kept in an ENTRIES-deep tagged buffer.
//  Later line reads that hit the buffer are served without AXI traffic.
//  Dcache writes invalidate matching entries.
// PARAMETERS
//  LINE_W       128  cache line width in bits; LINE_BYTES = LINE_W/8
//  FETCH_LINES  2    lines per AXI read; power of 2, >=2
//  ENTRIES      4    buffer slots; power of 2, >= FETCH_LINES-1
//  ADDR_W       32   address width
// PORTS
//  clk            in   1                  clock
//  resetn         in   1                  synchronous, active-low reset
//  cache_rd_req   in   1                  dcache read request
//  cache_rd_type  in   1                  1 = line read (bufferable), 0 = word/uncached (pass-through)
//  cache_rd_addr  in   ADDR_W             read address; line-aligned when type=1
//  cache_rd_rdy   out  1                  request accepted this cycle
//  cache_ret_valid out 1                  return data valid
//  cache_ret_data out  LINE_W             returned line
//  cache_wr_req   in   1                  dcache write (snoop)
//  cache_wr_addr  in   ADDR_W             write byte address; any entry whose line contains it is invalidated
//  axi_rd_req     out  1                  bridge read request
//  axi_rd_type    out  1                  = cache_rd_type
//  axi_rd_addr    out  ADDR_W             = cache_rd_addr
//  axi_rd_rdy     in   1                  bridge accepted request
//  axi_ret_valid  in   1                  bridge data valid (single beat)
//  axi_ret_data   in   LINE_W*FETCH_LINES line k at bits [k*LINE_W +: LINE_W]
//  hit_cnt        out  32                 buffer hits since reset; wraps at 2^32
// BEHAVIOUR
//  FSM: IDLE, MISS (one AXI read outstanding), HIT (buffered line returning). Reset -> IDLE.
//  Reset clears all valid bits, the round-robin pointer and hit_cnt.
//  Reset values: cache_ret_valid=0, cache_rd_rdy=0, axi_rd_req=0; hit_cnt=0; data outputs are don't-care.
//  hit = IDLE & cache_rd_req & type=1 & some valid entry tag == cache_rd_addr & no same-cycle invalidate of that line.
//  IDLE, hit:
//   - axi_rd_req=0, cache_rd_rdy=1 (combinational).
//   - Latch entry data, invalidate the entry, hit_cnt++, go to HIT.
//  IDLE, non-hit:
//   - axi_rd_req=cache_rd_req, cache_rd_rdy=axi_rd_rdy.
//   - On req&rdy: latch address and type, go to MISS.
//  HIT: cache_ret_valid=1 with latched line (1-cycle latency after accept); cache_rd_rdy=0; go to IDLE.
//  MISS: cache_rd_rdy=0, axi_rd_req=0.
//   - cache_ret_valid=axi_ret_valid; cache_ret_data=axi_ret_data[LINE_W-1:0] (combinational).
//   - On axi_ret_valid go to IDLE.
//   - If the latched type=1, also on axi_ret_valid:
//     - Invalidate any entry whose tag equals latched_addr + k*LINE_BYTES, k=1..FETCH_LINES-1.
//     - Write those lines into slots rr, rr+1, ... (mod ENTRIES), then rr += FETCH_LINES-1 (mod ENTRIES).
//     - Tag arithmetic is mod 2^ADDR_W; a tag may wrap to 0.
//  Invalidate: cache_wr_req clears every entry whose tag == cache_wr_addr & ~(LINE_BYTES-1), in any state.
//   - Invalidate wins over a same-cycle fill of that line: the line is not written valid.
//   - Invalidate wins over a same-cycle hit: the request is treated as a miss.
//  Type=0 requests are never looked up or buffered.
// STRUCTURE
//  Shared package pf_pkg: state encoding; LINE_BYTES, line-offset mask, rr pointer width as functions of the parameters.
//  Sub-module pf_entry_array: tag/valid/data storage, parallel tag compare giving hit index and data,
//   write-port and invalidate logic. Top holds the FSM, rr pointer, latches and hit_cnt.
// TESTING (LINE_W=128, FETCH_LINES=2, ENTRIES=4)
//  1 Line read 0x1000, AXI returns {B,A} -> cache_ret_data=A in the axi_ret_valid cycle; entry 0x1010 valid with B.
//  2 Then line read 0x1010 -> cache_rd_rdy=1 and axi_rd_req=0 the same cycle; next cycle ret_valid=1, data=B; hit_cnt=1.
//  3 Fill 0x2000 (0x2010 buffered), write 0x2018, line read 0x2010 -> axi_rd_req=1 addr 0x2010; hit_cnt unchanged.
//  4 Entry 0x3010 valid, type=0 read 0x3010 -> forwarded to AXI; cache gets axi_ret_data[127:0]; entry still valid.
//  5 Misses 0x0,0x100,0x200,0x300,0x400 -> 0x10 evicted (read misses); 0x410 hits. Miss 0xFFFFFFF0 -> tag 0x0 buffered.
//  6 Reset asserted during MISS -> FSM IDLE, ret_valid=0, hit_cnt=0; prior buffered line now misses.

Source files
------------

// File: rtl/pf_pkg.sv
// pf_pkg: shared state encoding and geometry helpers for the stream prefetch buffer
package pf_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_MISS, ST_HIT} pf_state_e;
  function automatic int line_bytes(input int line_w);
    return line_w / 8;
  endfunction
  function automatic logic [63:0] off_mask(input int line_w);
    return 64'(line_bytes(line_w) - 1);
  endfunction
  function automatic int rr_width(input int entries);
    return entries > 1 ? $clog2(entries) : 1;
  endfunction
endpackage

// File: rtl/pf_entry_array.sv
// pf_entry_array: tagged line storage with parallel lookup, multi-line fill and snoop invalidate
module pf_entry_array
  import pf_pkg::*;
#(
  parameter int LINE_W      = 128,
  parameter int FETCH_LINES = 2,
  parameter int ENTRIES     = 4,
  parameter int ADDR_W      = 32,
  parameter int RR_W        = rr_width(ENTRIES)
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [ADDR_W-1:0]                 lookup_addr_i,
  input  logic                              take_i,
  input  logic                              inv_req_i,
  input  logic [ADDR_W-1:0]                 inv_line_i,
  input  logic                              fill_en_i,
  input  logic [ADDR_W-1:0]                 fill_base_i,
  input  logic [RR_W-1:0]                   fill_rr_i,
  input  logic [LINE_W*(FETCH_LINES-1)-1:0] fill_data_i,
  output logic                              hit_o,
  output logic [LINE_W-1:0]                 hit_data_o
);
  localparam int LB = line_bytes(LINE_W);
  logic [ENTRIES-1:0] valid_q, valid_d, match;
  logic [ADDR_W-1:0]  tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tag_d [ENTRIES];
  logic [LINE_W-1:0]  data_q [ENTRIES];
  logic [LINE_W-1:0]  data_d [ENTRIES];
  logic [ADDR_W-1:0]  fill_tag [FETCH_LINES-1];
  logic [RR_W-1:0]    hit_idx, slot;
  // Tags of the extra lines carried by a fill; wrap mod 2^ADDR_W
  always_comb
    for (int k = 0; k < FETCH_LINES - 1; k++) fill_tag[k] = fill_base_i + ADDR_W'((k + 1) * LB);
  // Parallel tag compare; a same-cycle snoop of the line suppresses the hit
  always_comb begin
    hit_idx = '0;
    hit_data_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid_q[i] && tag_q[i] == lookup_addr_i && !(inv_req_i && tag_q[i] == inv_line_i);
      if (match[i]) begin
        hit_idx = RR_W'(i);
        hit_data_o = data_q[i];
      end
    end
    hit_o = |match;
  end
  // Invalidate snooped, consumed and about-to-be-refilled lines, then write the fill slots
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    data_d = data_q;
    slot = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if ((inv_req_i && tag_q[i] == inv_line_i) || (take_i && hit_idx == RR_W'(i))) valid_d[i] = 1'b0;
      for (int k = 0; k < FETCH_LINES - 1; k++)
        if (fill_en_i && tag_q[i] == fill_tag[k]) valid_d[i] = 1'b0;
    end
    if (fill_en_i)
      for (int k = 0; k < FETCH_LINES - 1; k++) begin
        slot = RR_W'((int'(fill_rr_i) + k) % ENTRIES);
        tag_d[slot] = fill_tag[k];
        data_d[slot] = fill_data_i[k*LINE_W +: LINE_W];
        valid_d[slot] = !(inv_req_i && fill_tag[k] == inv_line_i);
      end
  end
  // Only the valid bits need reset; tags and data are qualified by them
  always_ff @(posedge clk) begin
    valid_q <= resetn ? valid_d : '0;
    tag_q <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: rtl/stream_prefetch_buf.sv
// stream_prefetch_buf: next-line prefetch buffer between dcache read port and AXI read bridge
module stream_prefetch_buf
  import pf_pkg::*;
#(
  parameter int LINE_W      = 128,
  parameter int FETCH_LINES = 2,
  parameter int ENTRIES     = 4,
  parameter int ADDR_W      = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cache_rd_req,
  input  logic                          cache_rd_type,
  input  logic [ADDR_W-1:0]             cache_rd_addr,
  output logic                          cache_rd_rdy,
  output logic                          cache_ret_valid,
  output logic [LINE_W-1:0]             cache_ret_data,
  input  logic                          cache_wr_req,
  input  logic [ADDR_W-1:0]             cache_wr_addr,
  output logic                          axi_rd_req,
  output logic                          axi_rd_type,
  output logic [ADDR_W-1:0]             axi_rd_addr,
  input  logic                          axi_rd_rdy,
  input  logic                          axi_ret_valid,
  input  logic [LINE_W*FETCH_LINES-1:0] axi_ret_data,
  output logic [31:0]                   hit_cnt
);
  localparam int RR_W = rr_width(ENTRIES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(off_mask(LINE_W));
  pf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, inv_line;
  logic              type_q, type_d, arr_hit, hit, fill_en;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [LINE_W-1:0] ret_q, ret_d, arr_data;
  assign inv_line = cache_wr_addr & ~OFF_MASK;
  assign hit = resetn && state_q == ST_IDLE && cache_rd_req && cache_rd_type && arr_hit;
  assign fill_en = resetn && state_q == ST_MISS && axi_ret_valid && type_q;
  assign axi_rd_type = cache_rd_type;
  assign axi_rd_addr = cache_rd_addr;
  assign hit_cnt = hit_cnt_q;
  pf_entry_array #(
    .LINE_W(LINE_W), .FETCH_LINES(FETCH_LINES), .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .RR_W(RR_W)
  ) u_array (
    .clk          (clk),
    .resetn       (resetn),
    .lookup_addr_i(cache_rd_addr),
    .take_i       (hit),
    .inv_req_i    (cache_wr_req),
    .inv_line_i   (inv_line),
    .fill_en_i    (fill_en),
    .fill_base_i  (addr_q),
    .fill_rr_i    (rr_q),
    .fill_data_i  (axi_ret_data[LINE_W*FETCH_LINES-1:LINE_W]),
    .hit_o        (arr_hit),
    .hit_data_o   (arr_data)
  );
  // FSM next state and handshake outputs; handshakes held low while in reset
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    type_d = type_q;
    rr_d = rr_q;
    hit_cnt_d = hit_cnt_q;
    ret_d = ret_q;
    cache_rd_rdy = 1'b0;
    axi_rd_req = 1'b0;
    cache_ret_valid = 1'b0;
    cache_ret_data = axi_ret_data[LINE_W-1:0];
    case (state_q)
      ST_IDLE:
        if (hit) begin
          cache_rd_rdy = 1'b1;
          ret_d = arr_data;
          hit_cnt_d = hit_cnt_q + 32'd1;
          state_d = ST_HIT;
        end else begin
          axi_rd_req = cache_rd_req;
          cache_rd_rdy = axi_rd_rdy;
          if (cache_rd_req && axi_rd_rdy) begin
            addr_d = cache_rd_addr;
            type_d = cache_rd_type;
            state_d = ST_MISS;
          end
        end
      ST_HIT: begin
        cache_ret_valid = 1'b1;
        cache_ret_data = ret_q;
        state_d = ST_IDLE;
      end
      ST_MISS: begin
        cache_ret_valid = axi_ret_valid;
        state_d = axi_ret_valid ? ST_IDLE : ST_MISS;
        rr_d = fill_en ? RR_W'((int'(rr_q) + FETCH_LINES - 1) % ENTRIES) : rr_q;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!resetn) begin
      cache_rd_rdy = 1'b0;
      axi_rd_req = 1'b0;
      cache_ret_valid = 1'b0;
    end
  end
  // State, pointer and counter registers; latches need no reset
  always_ff @(posedge clk) begin
    state_q <= resetn ? state_d : ST_IDLE;
    rr_q <= resetn ? rr_d : '0;
    hit_cnt_q <= resetn ? hit_cnt_d : '0;
    addr_q <= addr_d;
    type_q <= type_d;
    ret_q <= ret_d;
  end
endmodule

// File: tb/tb_stream_prefetch_buf.sv
// tb_stream_prefetch_buf: randomized and directed checks against a slot-level buffer model
module tb_stream_prefetch_buf;
  localparam int LW = 128;
  localparam int FL = 2;
  localparam int EN = 4;
  localparam int AW = 32;
  logic clk, resetn;
  logic cache_rd_req, cache_rd_type, cache_rd_rdy, cache_ret_valid;
  logic [AW-1:0] cache_rd_addr, cache_wr_addr, axi_rd_addr;
  logic [LW-1:0] cache_ret_data;
  logic cache_wr_req, axi_rd_req, axi_rd_type, axi_rd_rdy, axi_ret_valid;
  logic [LW*FL-1:0] axi_ret_data;
  logic [31:0] hit_cnt;
  int vectors = 0;
  int errors = 0;
  bit m_v[EN];
  logic [AW-1:0] m_tag[EN];
  logic [LW-1:0] m_data[EN];
  int m_rr;
  logic [31:0] m_hits;

  stream_prefetch_buf #(.LINE_W(LW), .FETCH_LINES(FL), .ENTRIES(EN), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn),
    .cache_rd_req(cache_rd_req), .cache_rd_type(cache_rd_type), .cache_rd_addr(cache_rd_addr),
    .cache_rd_rdy(cache_rd_rdy), .cache_ret_valid(cache_ret_valid), .cache_ret_data(cache_ret_data),
    .cache_wr_req(cache_wr_req), .cache_wr_addr(cache_wr_addr),
    .axi_rd_req(axi_rd_req), .axi_rd_type(axi_rd_type), .axi_rd_addr(axi_rd_addr),
    .axi_rd_rdy(axi_rd_rdy), .axi_ret_valid(axi_ret_valid), .axi_ret_data(axi_ret_data),
    .hit_cnt(hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_reset();
    for (int i = 0; i < EN; i++) m_v[i] = 1'b0;
    m_rr = 0;
    m_hits = 32'd0;
  endfunction

  function automatic int m_find(input logic [AW-1:0] a);
    for (int i = 0; i < EN; i++) if (m_v[i] && m_tag[i] == a) return i;
    return -1;
  endfunction

  function automatic void m_inv(input logic [AW-1:0] a);
    for (int i = 0; i < EN; i++) if (m_tag[i] == (a & ~32'hF)) m_v[i] = 1'b0;
  endfunction

  function automatic void m_fill(input logic [AW-1:0] base, input logic [LW*FL-1:0] d);
    logic [AW-1:0] t;
    for (int k = 1; k < FL; k++) begin
      t = base + 32'(k * 16);
      m_inv(t);
      m_tag[(m_rr + k - 1) % EN] = t;
      m_data[(m_rr + k - 1) % EN] = d[k*LW +: LW];
      m_v[(m_rr + k - 1) % EN] = 1'b1;
    end
    m_rr = (m_rr + FL - 1) % EN;
  endfunction

  task automatic do_write(input logic [AW-1:0] wa);
    cache_wr_req = 1'b1;
    cache_wr_addr = wa;
    @(posedge clk); #1;
    cache_wr_req = 1'b0;
    m_inv(wa);
  endtask

  // want: -1 = follow the model, 0/1 = scenario-mandated miss/hit
  task automatic do_read(input logic [AW-1:0] a, input logic t, input int want,
                         input logic wr_req_en, input logic wr_ret_en, input logic [AW-1:0] wa);
    int idx, n;
    bit eh;
    logic [LW*FL-1:0] d;
    logic [LW-1:0] ed;
    if (wr_req_en) m_inv(wa);
    idx = t ? m_find(a) : -1;
    eh = (want < 0) ? (idx >= 0) : (want == 1);
    ed = (idx >= 0) ? m_data[idx] : '0;
    cache_rd_req = 1'b1; cache_rd_addr = a; cache_rd_type = t;
    cache_wr_req = wr_req_en; cache_wr_addr = wa;
    if (eh) begin
      @(negedge clk); vectors++;
      if (cache_rd_rdy !== 1'b1 || axi_rd_req !== 1'b0) begin
        errors++;
        $display("FAIL hit_accept addr=%h rdy=%b axi_req=%b required rdy=1 axi_req=0", a, cache_rd_rdy, axi_rd_req);
      end
      @(posedge clk); #1;
      cache_rd_req = 1'b0; cache_wr_req = 1'b0;
      m_hits++;
      if (idx >= 0) m_v[idx] = 1'b0;
      @(negedge clk); vectors++;
      if (cache_ret_valid !== 1'b1 || cache_ret_data !== ed) begin
        errors++;
        $display("FAIL hit_return addr=%h valid=%b data=%h required valid=1 data=%h", a, cache_ret_valid, cache_ret_data, ed);
      end
      @(posedge clk); #1;
    end else begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk); vectors++;
        if (axi_rd_req !== 1'b1 || axi_rd_addr !== a || axi_rd_type !== t || cache_rd_rdy !== 1'b0) begin
          errors++;
          $display("FAIL miss_wait addr=%h axi_req=%b axi_addr=%h axi_type=%b rdy=%b required 1 %h %b 0", a, axi_rd_req, axi_rd_addr, axi_rd_type, cache_rd_rdy, a, t);
        end
        @(posedge clk); #1;
        cache_wr_req = 1'b0;
      end
      axi_rd_rdy = 1'b1;
      @(negedge clk); vectors++;
      if (axi_rd_req !== 1'b1 || axi_rd_addr !== a || cache_rd_rdy !== 1'b1) begin
        errors++;
        $display("FAIL miss_accept addr=%h axi_req=%b axi_addr=%h rdy=%b required 1 %h 1", a, axi_rd_req, axi_rd_addr, cache_rd_rdy, a);
      end
      @(posedge clk); #1;
      cache_rd_req = 1'b0; axi_rd_rdy = 1'b0; cache_wr_req = 1'b0;
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk); vectors++;
        if (cache_ret_valid !== 1'b0 || cache_rd_rdy !== 1'b0 || axi_rd_req !== 1'b0) begin
          errors++;
          $display("FAIL miss_pending valid=%b rdy=%b axi_req=%b required 0 0 0", cache_ret_valid, cache_rd_rdy, axi_rd_req);
        end
        @(posedge clk); #1;
      end
      d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      axi_ret_data = d; axi_ret_valid = 1'b1;
      cache_wr_req = wr_ret_en; cache_wr_addr = wa;
      @(negedge clk); vectors++;
      if (cache_ret_valid !== 1'b1 || cache_ret_data !== d[LW-1:0]) begin
        errors++;
        $display("FAIL miss_return addr=%h valid=%b data=%h required valid=1 data=%h", a, cache_ret_valid, cache_ret_data, d[LW-1:0]);
      end
      @(posedge clk); #1;
      axi_ret_valid = 1'b0; cache_wr_req = 1'b0;
      if (t) m_fill(a, d);
      if (wr_ret_en) m_inv(wa);
    end
    @(negedge clk); vectors++;
    if (hit_cnt !== m_hits) begin
      errors++;
      $display("FAIL hit_cnt after addr=%h got=%0d required=%0d", a, hit_cnt, m_hits);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cache_rd_req = 1'b1; cache_rd_type = 1'b1; cache_rd_addr = 32'h0; axi_rd_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); vectors++;
    if (cache_ret_valid !== 1'b0 || cache_rd_rdy !== 1'b0 || axi_rd_req !== 1'b0 || hit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset valid=%b rdy=%b axi_req=%b hit_cnt=%0d required 0 0 0 0", cache_ret_valid, cache_rd_rdy, axi_rd_req, hit_cnt);
    end
    @(posedge clk); #1;
    cache_rd_req = 1'b0; axi_rd_rdy = 1'b0; resetn = 1'b1;
    m_reset();
  endtask

  task automatic test_fill_hit();
    do_read(32'h1000, 1'b1, 0, 1'b0, 1'b0, 32'h0);
    do_read(32'h1010, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    do_read(32'h1010, 1'b1, 0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_invalidate();
    do_read(32'h2000, 1'b1, 0, 1'b0, 1'b0, 32'h0);
    do_write(32'h2018);
    do_read(32'h2010, 1'b1, 0, 1'b0, 1'b0, 32'h0);
    do_read(32'h2800, 1'b1, 0, 1'b0, 1'b0, 32'h0);
    do_read(32'h2810, 1'b1, 0, 1'b1, 1'b0, 32'h2814);
    do_read(32'h2900, 1'b1, 0, 1'b0, 1'b1, 32'h291C);
    do_read(32'h2910, 1'b1, 0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_passthrough();
    do_read(32'h3000, 1'b1, 0, 1'b0, 1'b0, 32'h0);
    do_read(32'h3010, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    do_read(32'h3010, 1'b1, 1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_eviction();
    for (int i = 0; i < 5; i++) do_read(32'(i * 32'h100), 1'b1, 0, 1'b0, 1'b0, 32'h0);
    do_read(32'h10, 1'b1, 0, 1'b0, 1'b0, 32'h0);
    do_read(32'h410, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    do_read(32'hFFFF_FFF0, 1'b1, 0, 1'b0, 1'b0, 32'h0);
    do_read(32'h0, 1'b1, 1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic [AW-1:0] a, wa;
    for (int i = 0; i < 80; i++) begin
      a = 32'h5000 + 32'($urandom_range(0, 7) * 16);
      wa = 32'h5000 + 32'($urandom_range(0, 127));
      if ($urandom_range(0, 5) == 0) do_write(wa);
      do_read(a, $urandom_range(0, 3) != 0, -1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, wa);
    end
  endtask

  task automatic test_reset_in_miss();
    do_read(32'h7000, 1'b1, 0, 1'b0, 1'b0, 32'h0);
    cache_rd_req = 1'b1; cache_rd_type = 1'b1; cache_rd_addr = 32'h8000; axi_rd_rdy = 1'b1;
    @(posedge clk); #1;
    cache_rd_req = 1'b0; axi_rd_rdy = 1'b0; resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    m_reset();
    @(negedge clk); vectors++;
    if (cache_ret_valid !== 1'b0 || hit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_in_miss valid=%b hit_cnt=%0d required 0 0", cache_ret_valid, hit_cnt);
    end
    @(posedge clk); #1;
    do_read(32'h7010, 1'b1, 0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    resetn = 1'b0; cache_rd_req = 1'b0; cache_rd_type = 1'b0; cache_rd_addr = '0;
    cache_wr_req = 1'b0; cache_wr_addr = '0; axi_rd_rdy = 1'b0; axi_ret_valid = 1'b0; axi_ret_data = '0;
    m_reset();
    test_reset();
    test_fill_hit();
    test_invalidate();
    test_passthrough();
    test_eviction();
    test_random();
    test_reset_in_miss();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
